uart_rx_fifo: RTL and testbench

Receive buffer placed directly downstream of the UART receiver.
- Captures each completed byte (receiver data bus qualified by its one-cycle done strobe) into a circular FIFO.
- Presents bytes to the bus/host side through a valid/ready read interface.
- Tracks overrun when the receiver delivers a byte into a full buffer.
- Optionally flags a receive idle-timeout, so the host can drain partial bursts without polling.

---
 rtl/uart_rx_fifo_if.sv | 31 +++
 rtl/uart_rx_fifo.sv | 104 ++++++++++
 tb/tb_uart_rx_fifo.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver/host side and the receive FIFO.
// master drives strobes and read-ready; slave (the FIFO) returns status and head data.
interface uart_rx_fifo_if #(
   parameter int DBIT  = 8,
   parameter int DEPTH = 16
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic            tick;
   logic            wr_en;
   logic [DBIT-1:0] wr_data;
   logic            rd_valid;
   logic            rd_ready;
   logic [DBIT-1:0] rd_data;
   logic [LW-1:0]   level;
   logic            full;
   logic            empty;
   logic            overrun;
   logic            ovr_clr;
   logic            timeout;

   modport master (
      output tick, wr_en, wr_data, rd_ready, ovr_clr,
      input  rd_valid, rd_data, level, full, empty, overrun, timeout
   );

   modport slave (
      input  tick, wr_en, wr_data, rd_ready, ovr_clr,
      output rd_valid, rd_data, level, full, empty, overrun, timeout
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO behind the UART receiver: FWFT read, sticky overrun.
// Optional idle-timeout flag is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
   parameter int DBIT          = 8,
   parameter int DEPTH         = 16,
   parameter int TIMEOUT_TICKS = 640
) (
   input logic             clk,
   input logic             rst_n,
   uart_rx_fifo_if.slave   bus_io
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DBIT-1:0] mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            ovr_q, ovr_d;
   logic [PW-1:0]   level;
   logic            full, empty, push, pop, drop;

   // Extra pointer MSB separates full (difference DEPTH) from empty (difference 0).
   assign level = wr_ptr_q - rd_ptr_q;
   assign empty = (level == '0);
   assign full  = (level == PW'(DEPTH));

   assign pop  = !empty && bus_io.rd_ready;
   assign push = bus_io.wr_en && (!full || pop);
   assign drop = bus_io.wr_en && full && !pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovr_d    = ovr_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (drop)                ovr_d = 1'b1;
      else if (bus_io.ovr_clr) ovr_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovr_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovr_q    <= ovr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus_io.wr_data;
   end

   assign bus_io.rd_valid = !empty;
   assign bus_io.rd_data  = mem_q[rd_ptr_q[AW-1:0]];
   assign bus_io.level    = level;
   assign bus_io.full     = full;
   assign bus_io.empty    = empty;
   assign bus_io.overrun  = ovr_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_TICKS);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_TICKS - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tmo_q, tmo_d;
   logic          idle_clr;

   // Any traffic, or nothing buffered, restarts the silence measurement.
   assign idle_clr = push || pop || empty;

   always_comb begin
      cnt_d = cnt_q;
      tmo_d = tmo_q;
      if (idle_clr) begin
         cnt_d = '0;
         tmo_d = 1'b0;
      end else if (bus_io.tick) begin
         if (cnt_q == CNT_MAX) tmo_d = 1'b1;
         else                  cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end

   assign bus_io.timeout = tmo_q;
`else
   localparam int UNUSED_TIMEOUT_TICKS = TIMEOUT_TICKS;
   logic unused_tick;
   assign unused_tick    = bus_io.tick;
   assign bus_io.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed table, corner sequences, randomized traffic vs queue model.
module tb_uart_rx_fifo;
   localparam int DBIT  = 8;
   localparam int DEPTH = 16;
   localparam int TT    = 8;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_FIFO_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uart_rx_fifo_if #(.DBIT(DBIT), .DEPTH(DEPTH)) bus ();

   uart_rx_fifo #(.DBIT(DBIT), .DEPTH(DEPTH), .TIMEOUT_TICKS(TT)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   // Reference model: a queue of stored bytes plus flags.
   logic [DBIT-1:0] q[$];
   bit  m_ovr, m_tmo;
   int  m_idle;
   int  vecs, errs;

   typedef struct {
      bit              wr;
      logic [DBIT-1:0] d;
      bit              rdy;
      bit              clr;
      int              lvl;
      bit              vld;
      logic [DBIT-1:0] dat;
      bit              ovr;
   } vec_t;
   vec_t tbl[9];

   task automatic check_model(input string name);
      logic [LW+4:0]   exp_s, act_s;
      bit              ev;
      ev    = (q.size() != 0);
      exp_s = {ev, LW'(q.size()), q.size() == DEPTH, q.size() == 0, m_ovr, TMO_EN ? m_tmo : 1'b0};
      act_s = {bus.rd_valid, bus.level, bus.full, bus.empty, bus.overrun, bus.timeout};
      vecs++;
      if (act_s !== exp_s || (ev && bus.rd_data !== q[0])) begin
         errs++;
         $display("FAIL %s: status act=%b exp=%b data act=%h exp=%h", name, act_s, exp_s,
                  bus.rd_data, ev ? q[0] : 'x);
      end
   endtask

   task automatic expect_eq(input string name, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: act=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic cycle(input bit wr, input logic [DBIT-1:0] d, input bit rdy,
                        input bit clr, input bit tk, input string name);
      bit pop, push, drop, full;
      bus.wr_en = wr; bus.wr_data = d; bus.rd_ready = rdy; bus.ovr_clr = clr; bus.tick = tk;
      rst_n = 1'b1;
      full = (q.size() == DEPTH);
      pop  = (q.size() != 0) && rdy;
      push = wr && (!full || pop);
      drop = wr && full && !pop;
      if (push || pop || q.size() == 0) begin
         m_idle = 0;
         m_tmo  = 1'b0;
      end else if (tk) begin
         if (m_idle >= TT - 1) m_tmo = 1'b1;
         m_idle++;
      end
      @(posedge clk);
      #1;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(d);
      if (drop)     m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      check_model(name);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.wr_en = 0; bus.wr_data = '0; bus.rd_ready = 0; bus.ovr_clr = 0; bus.tick = 0;
      @(posedge clk);
      #1;
      q.delete();
      m_ovr = 0; m_tmo = 0; m_idle = 0;
      check_model("reset");
      rst_n = 1'b1;
   endtask

   initial begin
      logic [DBIT-1:0] last;
      vecs = 0; errs = 0;
      tbl[0] = '{1, 8'hA5, 0, 0, 1, 1, 8'hA5, 0};
      tbl[1] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
      tbl[2] = '{1, 8'h3C, 1, 0, 1, 1, 8'h3C, 0};
      tbl[3] = '{1, 8'h11, 0, 0, 2, 1, 8'h3C, 0};
      tbl[4] = '{1, 8'h22, 1, 0, 2, 1, 8'h11, 0};
      tbl[5] = '{0, 8'h00, 1, 0, 1, 1, 8'h22, 0};
      tbl[6] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
      tbl[7] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
      tbl[8] = '{0, 8'h00, 0, 1, 0, 0, 8'h00, 0};

      do_reset();
      for (int i = 0; i < 9; i++) begin
         cycle(tbl[i].wr, tbl[i].d, tbl[i].rdy, tbl[i].clr, 1'b0, "tbl");
         expect_eq($sformatf("tbl%0d_level", i), int'(bus.level), tbl[i].lvl);
         expect_eq($sformatf("tbl%0d_valid", i), int'(bus.rd_valid), int'(tbl[i].vld));
         if (tbl[i].vld) expect_eq($sformatf("tbl%0d_data", i), int'(bus.rd_data), int'(tbl[i].dat));
         expect_eq($sformatf("tbl%0d_ovr", i), int'(bus.overrun), int'(tbl[i].ovr));
      end

      // Fill, overflow, drain in order, then clear overrun.
      for (int i = 0; i < DEPTH; i++) cycle(1, DBIT'(i), 0, 0, 0, "fill");
      cycle(1, 8'h55, 0, 0, 0, "overflow");
      expect_eq("ovf_level", int'(bus.level), 16);
      expect_eq("ovf_full", int'(bus.full), 1);
      expect_eq("ovf_overrun", int'(bus.overrun), 1);
      for (int i = 0; i < DEPTH; i++) begin
         expect_eq("drain_order", int'(bus.rd_data), i);
         cycle(0, 0, 1, 0, 0, "drain");
      end
      expect_eq("drain_empty", int'(bus.empty), 1);
      cycle(0, 0, 0, 1, 0, "ovr_clr");
      expect_eq("ovr_cleared", int'(bus.overrun), 0);

      // Push and pop together while full.
      for (int i = 0; i < DEPTH; i++) cycle(1, DBIT'(i), 0, 0, 0, "fill2");
      expect_eq("full_head", int'(bus.rd_data), 0);
      cycle(1, 8'h77, 1, 0, 0, "full_pushpop");
      expect_eq("fpp_level", int'(bus.level), 16);
      expect_eq("fpp_overrun", int'(bus.overrun), 0);
      expect_eq("fpp_head", int'(bus.rd_data), 1);
      last = '0;
      for (int i = 0; i < DEPTH; i++) begin
         last = bus.rd_data;
         cycle(0, 0, 1, 0, 0, "drain2");
      end
      expect_eq("fpp_last", int'(last), 8'h77);

      // Push and pop together while empty, then run across the pointer wrap.
      cycle(1, 8'h3C, 1, 0, 0, "empty_pushpop");
      expect_eq("epp_level", int'(bus.level), 1);
      expect_eq("epp_data", int'(bus.rd_data), 8'h3C);
      for (int i = 0; i < 40; i++) cycle(1, DBIT'(8'h80 + i), 1, 0, 0, "wrap");
      expect_eq("wrap_level", int'(bus.level), 1);
      expect_eq("wrap_data", int'(bus.rd_data), 8'h80 + 39);

      // Drop and clear in the same cycle, then reset mid-burst at level 5.
      do_reset();
      for (int i = 0; i < DEPTH; i++) cycle(1, DBIT'(i + 16), 0, 0, 0, "fill3");
      cycle(1, 8'hAA, 0, 0, 0, "drop");
      cycle(1, 8'hBB, 0, 1, 0, "drop_clr");
      expect_eq("setwins_overrun", int'(bus.overrun), 1);
      for (int i = 0; i < 11; i++) cycle(0, 0, 1, 0, 0, "to_five");
      expect_eq("mid_level", int'(bus.level), 5);
      do_reset();
      expect_eq("rst_level", int'(bus.level), 0);
      expect_eq("rst_empty", int'(bus.empty), 1);
      expect_eq("rst_overrun", int'(bus.overrun), 0);

      // Idle timeout after TT ticks with one byte held.
      cycle(1, 8'h42, 0, 0, 0, "tmo_push");
      for (int i = 0; i < TT - 1; i++) begin
         cycle(0, 0, 0, 0, 1, "tmo_tick");
         cycle(0, 0, 0, 0, 0, "tmo_gap");
      end
      expect_eq("tmo_before", int'(bus.timeout), 0);
      cycle(0, 0, 0, 0, 1, "tmo_last");
      expect_eq("tmo_set", int'(bus.timeout), int'(TMO_EN));
      cycle(0, 0, 1, 0, 0, "tmo_pop");
      expect_eq("tmo_cleared", int'(bus.timeout), 0);

      // Randomized traffic with alternating fill/drain bias.
      for (int i = 0; i < 3000; i++) begin
         bit ph;
         ph = ((i / 150) % 2) == 1;
         if ($urandom_range(0, 299) == 0) do_reset();
         else cycle($urandom_range(0, 1) == 1, DBIT'($urandom),
                    ph ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
